// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad path.
//   filter_state_t / ST_*  : debounce FSM state encoding
//   key_result_t           : frame result, key code qualified by a separate valid flag
//   map_key()              : physical (row, column) position -> 4-bit key code
//   col_drive()            : column index -> active-low one-cold column drive
package keypad_pkg;

    typedef logic [1:0] filter_state_t;

    localparam filter_state_t ST_IDLE         = 2'd0;
    localparam filter_state_t ST_PRESS_WAIT   = 2'd1;
    localparam filter_state_t ST_HELD         = 2'd2;
    localparam filter_state_t ST_RELEASE_WAIT = 2'd3;

    // "No key" is expressed by valid = 0, never by a reserved code value,
    // because all 16 codes are real keys.
    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } key_result_t;

    // Keypad legend, rows top to bottom, columns left to right:
    //   1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    function automatic logic [3:0] map_key(input logic [1:0] row_idx,
                                           input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'h0;
            4'hD:    code = 4'hF;
            4'hE:    code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col_idx);
        return ~(4'b0001 << col_idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Bundles the keypad pins and the decoded key outputs.
//   row       : keypad rows, active-low, asynchronous (driven by the keypad)
//   col       : column drive, active-low, exactly one bit low
//   decode    : code of the last accepted key
//   key_valid : high while an accepted key is held
//   key_press : one-cycle pulse per accepted press
// master = scanner side, slave = keypad / downstream consumer side.
interface keypad_scanner_if;

    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] decode;
    logic       key_valid;
    logic       key_press;

    modport master (
        input  row,
        output col,
        output decode,
        output key_valid,
        output key_press
    );

    modport slave (
        output row,
        input  col,
        input  decode,
        input  key_valid,
        input  key_press
    );

endinterface

// File: rtl/keypad_frame_filter.sv
// keypad_frame_filter
// Debounce FSM evaluated once per complete scan frame. A press is accepted
// after DEBOUNCE_SCANS identical KEY frames, a release after DEBOUNCE_SCANS
// frames that do not show the held key.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   frame_strobe  : one-cycle strobe, frame result below is valid this cycle
//   frame_valid   : frame contained exactly one pressed key
//   frame_code    : code of that key
//   decode        : last accepted key code, held after release
//   key_valid     : high while the accepted key is held
//   key_press     : one-cycle pulse when a new press is accepted
module keypad_frame_filter
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_strobe,
    input  logic       frame_valid,
    input  logic [3:0] frame_code,
    output logic [3:0] decode,
    output logic       key_valid,
    output logic       key_press
);

    localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(DEBOUNCE_SCANS);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);

    filter_state_t     state;
    logic [3:0]        cand;
    logic [STAB_W-1:0] stab;
    logic [STAB_W-1:0] stab_inc;
    logic              same_held;

    assign stab_inc  = stab + STAB_ONE;
    assign same_held = frame_valid && (frame_code == decode);

    // stab counts consecutive supporting frames; it never exceeds
    // DEBOUNCE_SCANS because reaching it always changes state.
    // With DEBOUNCE_SCANS == 1 the wait states are skipped entirely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cand      <= 4'h0;
            stab      <= '0;
            decode    <= 4'h0;
            key_valid <= 1'b0;
            key_press <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (frame_strobe) begin
                case (state)
                    ST_IDLE: begin
                        if (frame_valid) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= ST_HELD;
                                decode    <= frame_code;
                                key_valid <= 1'b1;
                                key_press <= 1'b1;
                                stab      <= '0;
                            end else begin
                                state <= ST_PRESS_WAIT;
                                cand  <= frame_code;
                                stab  <= STAB_ONE;
                            end
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!frame_valid) begin
                            state <= ST_IDLE;
                            stab  <= '0;
                        end else if (frame_code != cand) begin
                            cand <= frame_code;
                            stab <= STAB_ONE;
                        end else if (stab_inc == STAB_DONE) begin
                            state     <= ST_HELD;
                            decode    <= cand;
                            key_valid <= 1'b1;
                            key_press <= 1'b1;
                            stab      <= '0;
                        end else begin
                            stab <= stab_inc;
                        end
                    end
                    ST_HELD: begin
                        if (!same_held) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= ST_IDLE;
                                key_valid <= 1'b0;
                            end else begin
                                state <= ST_RELEASE_WAIT;
                                stab  <= STAB_ONE;
                            end
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (same_held) begin
                            state <= ST_HELD;
                            stab  <= '0;
                        end else if (stab_inc == STAB_DONE) begin
                            state     <= ST_IDLE;
                            key_valid <= 1'b0;
                            stab      <= '0;
                        end else begin
                            stab <= stab_inc;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        stab  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Column-drive scanner for the player B 4x4 keypad. Each column is driven
// low for SCAN_DIV cycles; rows are sampled at the end of each dwell, and
// after the fourth column a frame result (exactly one pressed key, or none)
// is handed to the debounce filter.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : keypad_scanner_if.master (row in; col, decode, key_valid,
//          key_press out)
// SCAN_DIV must be at least 4, DEBOUNCE_SCANS at least 1, and CNT_W wide
// enough to hold SCAN_DIV-1.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int CNT_W          = 17
) (
    input  logic               clk,
    input  logic               rst,
    keypad_scanner_if.master   bus
);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [CNT_W-1:0] dwell_cnt;
    logic [1:0]       col_idx;
    logic             dwell_end;

    logic [1:0]       low_total;
    logic [3:0]       acc_code;
    logic [3:0]       sample_low;
    logic [2:0]       sample_cnt;
    logic [1:0]       sample_row;
    logic [2:0]       sum_total;
    logic [1:0]       merged_total;
    logic [3:0]       merged_code;

    key_result_t      frame_result;
    logic             frame_strobe;

    // Rows come straight from the connector, so they are double-registered
    // before anything looks at them. Idle (all released) is 4'b1111.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= bus.row;
            row_sync <= row_meta;
        end
    end

    assign dwell_end = (dwell_cnt == CNT_W'(SCAN_DIV - 1));

    // Dwell counter and column index. Sampling at the last dwell cycle
    // leaves the synchronizer plenty of time to settle after a column switch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
        end else if (dwell_end) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
        end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end

    // Column drive is decoded from the index register, so reset forces
    // 4'b1110 immediately and exactly one column is low at all times.
    assign bus.col = col_drive(col_idx);

    // Low-bit count and row position of the current column's sample.
    always_comb begin
        sample_low = ~row_sync;
        sample_cnt = 3'(sample_low[0]) + 3'(sample_low[1])
                   + 3'(sample_low[2]) + 3'(sample_low[3]);
        sample_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (sample_low[r]) begin
                sample_row = 2'(r);
            end
        end
    end

    // low_total saturates at 2, which already means "ghost or multi-press".
    // The code is only captured when this sample brings the total to one.
    always_comb begin
        sum_total    = {1'b0, low_total} + sample_cnt;
        merged_total = (sum_total >= 3'd2) ? 2'd2 : sum_total[1:0];
        merged_code  = acc_code;
        if (low_total == 2'd0 && sample_cnt == 3'd1) begin
            merged_code = map_key(sample_row, col_idx);
        end
    end

    // Frame accumulator; cleared once the last column has been folded in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            low_total <= 2'd0;
            acc_code  <= 4'h0;
        end else if (dwell_end) begin
            if (col_idx == 2'd3) begin
                low_total <= 2'd0;
                acc_code  <= 4'h0;
            end else begin
                low_total <= merged_total;
                acc_code  <= merged_code;
            end
        end
    end

    // The frame result is combinational on the final sample cycle so the
    // filter's outputs change on the very next edge.
    assign frame_strobe       = dwell_end && (col_idx == 2'd3);
    assign frame_result.valid = (merged_total == 2'd1);
    assign frame_result.code  = merged_code;

    keypad_frame_filter #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_filter (
        .clk          (clk),
        .rst          (rst),
        .frame_strobe (frame_strobe),
        .frame_valid  (frame_result.valid),
        .frame_code   (frame_result.code),
        .decode       (bus.decode),
        .key_valid    (bus.key_valid),
        .key_press    (bus.key_press)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Drives a simulated keypad (mask of pressed keys, no ghosting) that reacts
// to the column drive, holds the mask constant over whole scan frames and
// checks decode / key_valid / key_press and the column rotation per frame.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 8;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int CNT_W          = 4;
    localparam int FRAME_CYCLES   = 4 * SCAN_DIV;

    localparam logic [15:0] K_NONE = 16'h0000;
    localparam logic [15:0] K_1    = 16'h0001;
    localparam logic [15:0] K_5    = 16'h0020;
    localparam logic [15:0] K_6    = 16'h0040;
    localparam logic [15:0] K_9    = 16'h0400;
    localparam logic [15:0] K_E    = 16'h4000;
    localparam logic [15:0] K_D    = 16'h8000;

    typedef struct {
        logic [15:0] mask;
        logic        exp_press;
        logic        exp_valid;
        logic [3:0]  exp_decode;
    } vector_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] key_mask = 16'h0000;
    logic [3:0]  row_drive;

    // Key legend indexed by row*4 + column.
    logic [3:0]  key_codes [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                    4'h4, 4'h5, 4'h6, 4'hB,
                                    4'h7, 4'h8, 4'h9, 4'hC,
                                    4'h0, 4'hF, 4'hE, 4'hD};

    int compare_count   = 0;
    int mismatch_count  = 0;
    int cycle_count     = 0;
    int last_press_cycle = -1;

    // Reference model state.
    logic       m_held;
    logic [3:0] m_decode;
    logic [3:0] m_cand;
    int         m_run;

    vector_t vectors[$];

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .CNT_W          (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kp_if)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_drive = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (kp_if.col[c] == 1'b0 && key_mask[r*4 + c]) begin
                    row_drive[r] = 1'b0;
                end
            end
        end
    end
    assign kp_if.row = row_drive;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_held   = 1'b0;
        m_decode = 4'h0;
        m_cand   = 4'h0;
        m_run    = 0;
    endtask

    // A frame is a KEY when exactly one key is down. Not holding: a key must
    // appear in DEBOUNCE_SCANS consecutive frames. Holding: the key is let go
    // after DEBOUNCE_SCANS consecutive frames that do not show it.
    task automatic modelFrame(input logic [15:0] mask, output logic exp_press);
        logic       is_key;
        logic [3:0] code;
        is_key = ($countones(mask) == 1);
        code   = 4'h0;
        for (int b = 0; b < 16; b++) begin
            if (mask[b]) code = key_codes[b];
        end
        exp_press = 1'b0;
        if (!m_held) begin
            if (!is_key) begin
                m_run = 0;
            end else if (m_run > 0 && code == m_cand) begin
                m_run++;
            end else begin
                m_cand = code;
                m_run  = 1;
            end
            if (m_run == DEBOUNCE_SCANS) begin
                m_held    = 1'b1;
                m_decode  = code;
                exp_press = 1'b1;
                m_run     = 0;
            end
        end else begin
            if (is_key && code == m_decode) m_run = 0;
            else m_run++;
            if (m_run == DEBOUNCE_SCANS) begin
                m_held = 1'b0;
                m_run  = 0;
            end
        end
    endtask

    // Holds a mask for one full frame (frame-aligned), counting key_press
    // pulses and column-drive errors, and advances the reference model.
    task automatic applyStimulus(input logic [15:0] mask, output int pulses,
                                 output int col_errors, output logic exp_press);
        logic [3:0] exp_col;
        key_mask   = mask;
        pulses     = 0;
        col_errors = 0;
        for (int i = 1; i <= FRAME_CYCLES; i++) begin
            @(posedge clk);
            cycle_count++;
            #1;
            exp_col = 4'hF;
            exp_col[(i / SCAN_DIV) % 4] = 1'b0;
            if (kp_if.col !== exp_col) col_errors++;
            if (kp_if.key_press === 1'b1) begin
                pulses++;
                last_press_cycle = cycle_count;
            end
        end
        modelFrame(mask, exp_press);
    endtask

    task automatic addVector(input logic [15:0] mask, input logic p,
                             input logic v, input logic [3:0] d);
        vector_t t;
        t.mask = mask; t.exp_press = p; t.exp_valid = v; t.exp_decode = d;
        vectors.push_back(t);
    endtask

    initial begin
        int         pulses;
        int         col_errors;
        logic       exp_press;
        int         k6_start;
        int         k6_press;
        logic [15:0] mask;
        int         run_len;
        int         kind;
        int         ka;
        int         kb;

        k6_start = 0;
        k6_press = -1;

        // Idle
        addVector(K_NONE, 0, 0, 4'h0);
        addVector(K_NONE, 0, 0, 4'h0);
        // Key 6 held five frames, then released
        addVector(K_6, 0, 0, 4'h0);
        addVector(K_6, 0, 0, 4'h0);
        addVector(K_6, 1, 1, 4'h6);
        addVector(K_6, 0, 1, 4'h6);
        addVector(K_6, 0, 1, 4'h6);
        addVector(K_NONE, 0, 1, 4'h6);
        addVector(K_NONE, 0, 1, 4'h6);
        addVector(K_NONE, 0, 0, 4'h6);
        // Key 5 bouncing on alternate frames, then stable
        for (int j = 0; j < 3; j++) begin
            addVector(K_5, 0, 0, 4'h6);
            addVector(K_NONE, 0, 0, 4'h6);
        end
        addVector(K_5, 0, 0, 4'h6);
        addVector(K_5, 0, 0, 4'h6);
        addVector(K_5, 1, 1, 4'h5);
        addVector(K_5, 0, 1, 4'h5);
        addVector(K_NONE, 0, 1, 4'h5);
        addVector(K_NONE, 0, 1, 4'h5);
        addVector(K_NONE, 0, 0, 4'h5);
        // Keys 1 and D together, then D released
        addVector(K_1 | K_D, 0, 0, 4'h5);
        addVector(K_1 | K_D, 0, 0, 4'h5);
        addVector(K_1 | K_D, 0, 0, 4'h5);
        addVector(K_1, 0, 0, 4'h5);
        addVector(K_1, 0, 0, 4'h5);
        addVector(K_1, 1, 1, 4'h1);
        addVector(K_NONE, 0, 1, 4'h1);
        addVector(K_NONE, 0, 1, 4'h1);
        addVector(K_NONE, 0, 0, 4'h1);
        // Key E accepted, two-frame release glitch, then real release
        addVector(K_E, 0, 0, 4'h1);
        addVector(K_E, 0, 0, 4'h1);
        addVector(K_E, 1, 1, 4'hE);
        addVector(K_E, 0, 1, 4'hE);
        addVector(K_NONE, 0, 1, 4'hE);
        addVector(K_NONE, 0, 1, 4'hE);
        addVector(K_E, 0, 1, 4'hE);
        addVector(K_E, 0, 1, 4'hE);
        addVector(K_NONE, 0, 1, 4'hE);
        addVector(K_NONE, 0, 1, 4'hE);
        addVector(K_NONE, 0, 0, 4'hE);

        // Reset values while rst is held low
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_col", kp_if.col, 4'b1110);
        checkOutput("reset_decode", kp_if.decode, 4'h0);
        checkOutput("reset_valid", kp_if.key_valid, 1'b0);
        checkOutput("reset_press", kp_if.key_press, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] table-driven frames: %0d", vectors.size());
        foreach (vectors[i]) begin
            if (i == 2) k6_start = cycle_count;
            applyStimulus(vectors[i].mask, pulses, col_errors, exp_press);
            if (i == 4) k6_press = last_press_cycle;
            checkOutput("tbl_press_pulses", pulses, 32'(vectors[i].exp_press));
            checkOutput("tbl_key_valid", kp_if.key_valid, vectors[i].exp_valid);
            checkOutput("tbl_decode", kp_if.decode, vectors[i].exp_decode);
            checkOutput("col_rotation", col_errors, 0);
        end
        checkOutput("k6_latency_in_window",
                    ((k6_press - k6_start) >= 96 && (k6_press - k6_start) <= 131), 1);

        // Reset in the middle of column 2 while key 9 is in PRESS_WAIT
        $display("[TB] mid-frame reset sequence");
        applyStimulus(K_9, pulses, col_errors, exp_press);
        checkOutput("pre_reset_pulses", pulses, 0);
        applyStimulus(K_9, pulses, col_errors, exp_press);
        checkOutput("pre_reset_pulses", pulses, 0);
        repeat (19) @(posedge clk);
        #2;
        checkOutput("col_before_reset", kp_if.col, 4'b1011);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_col", kp_if.col, 4'b1110);
        checkOutput("async_reset_decode", kp_if.decode, 4'h0);
        checkOutput("async_reset_valid", kp_if.key_valid, 1'b0);
        checkOutput("async_reset_press", kp_if.key_press, 1'b0);
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(K_9, pulses, col_errors, exp_press);
        checkOutput("restart_f1_pulses", pulses, 0);
        checkOutput("restart_f1_valid", kp_if.key_valid, 1'b0);
        checkOutput("restart_col_rotation", col_errors, 0);
        applyStimulus(K_9, pulses, col_errors, exp_press);
        checkOutput("restart_f2_pulses", pulses, 0);
        applyStimulus(K_9, pulses, col_errors, exp_press);
        checkOutput("restart_f3_pulses", pulses, 1);
        checkOutput("restart_f3_valid", kp_if.key_valid, 1'b1);
        checkOutput("restart_f3_decode", kp_if.decode, 4'h9);

        // Randomized runs of none / single / double presses against the model
        $display("[TB] randomized frames");
        for (int f = 0; f < 48; ) begin
            kind = $urandom_range(0, 3);
            ka   = $urandom_range(0, 15);
            kb   = (ka + $urandom_range(1, 15)) % 16;
            mask = 16'h0000;
            if (kind == 1 || kind == 2) mask[ka] = 1'b1;
            if (kind == 3) begin
                mask[ka] = 1'b1;
                mask[kb] = 1'b1;
            end
            run_len = $urandom_range(1, 5);
            for (int r = 0; r < run_len; r++) begin
                applyStimulus(mask, pulses, col_errors, exp_press);
                checkOutput("rnd_press_pulses", pulses, 32'(exp_press));
                checkOutput("rnd_key_valid", kp_if.key_valid, m_held);
                checkOutput("rnd_decode", kp_if.decode, m_decode);
                checkOutput("rnd_col_rotation", col_errors, 0);
                f++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
